dz_countdown: RTL and testbench
===============================

DZ_COUNTDOWN -- requirements
Module: dz_countdown

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- TICK_DIV, 1000, clk cycles per count step; legal range >= 2.
- START_VAL, 5, first value loaded on start; legal range 1..7.
- DB_CYCLES, 20, debounce stability window in clk cycles; legal range >= 1.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 btn_start  input  1  raw start/restart button, active-high, asynchronous to clk.
REQ-005 btn_pause  input  1  raw pause/resume toggle button, active-high, asynchronous to clk.
REQ-006 num  output  3  current count value; feeds the dot-matrix display stage directly; 0 = blank.
REQ-007 running  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle pulse when the count reaches 0.

Function
REQ-009 Each button SHALL pass through a 2-FF synchroniser, then (optionally) the debounce filter, then a rising-edge detector (filtered level high AND previous level low).
REQ-010 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-011 Start edge in any state SHALL load num=START_VAL, clear the prescaler and enter RUN on the same edge.
REQ-012 Pause edge in RUN SHALL enter PAUSE; pause edge in PAUSE SHALL return to RUN; pause edges in IDLE or DONE SHALL be ignored.
REQ-013 If start and pause edges occur in the same cycle, start SHALL win and pause SHALL be discarded.
REQ-014 In RUN the prescaler SHALL count 0..TICK_DIV-1 and wrap; when it equals TICK_DIV-1, num SHALL decrement by 1 on that edge.
REQ-015 In PAUSE the prescaler and num SHALL hold their values, so resume continues the partial step.
REQ-016 On a tick with num==1: num SHALL become 0, done SHALL be 1 for that single cycle, and the state SHALL become DONE.
REQ-017 num SHALL never wrap below 0.
REQ-018 DONE SHALL hold num=0 until a start edge; IDLE SHALL hold num=0.
REQ-019 Latency without debounce: num SHALL equal START_VAL after the 3rd rising clk edge at which btn_start is sampled high.
REQ-020 The first decrement SHALL occur TICK_DIV cycles after the load.
REQ-021 The prescaler width SHALL be clog2(TICK_DIV).
REQ-022 running SHALL be registered and equal (state==RUN).

Reset
REQ-023 rst high SHALL force, immediately and asynchronously: state=IDLE, num=0, running=0, done=0, prescaler=0, synchronisers/filters/edge registers=0.
REQ-024 Reset asserted mid-count SHALL abort the count without a done pulse.
REQ-025 A button held high through reset release SHALL NOT produce an edge until it is released and pressed again.

Configuration
REQ-026 Macro DZ_COUNTDOWN_DEBOUNCE_EN SHALL control the debounce filter.
- Defined: the filtered level changes only after the synchronised input differs from it for DB_CYCLES consecutive cycles; any shorter glitch resets the stability counter. Start latency becomes 3+DB_CYCLES edges.
- Undefined: the filtered level equals the synchronised level; no debounce counters are synthesised.

Verification (TICK_DIV=4, START_VAL=5, DB_CYCLES=3)
REQ-027 No debounce, btn_start pulsed high -> num=5 at edge 3, then 4,3,2,1 at edges 7,11,15,19, and num=0 with done=1 at edge 23; done=0 at edge 24; running=0 after that.
REQ-028 Pause at num=3, held off for 10 cycles -> num stays 3 and running=0; second pause -> the count resumes and the remaining partial step completes before num=2.
REQ-029 Start pressed at num=2 during RUN -> num=5, prescaler=0, and the next decrement occurs 4 cycles later.
REQ-030 In PAUSE, btn_start and btn_pause rise together -> RUN with num=5; the pause is ignored.
REQ-031 rst pulsed while num=4 -> num=0 and running=0 with no clock edge needed; done never pulses.
REQ-032 With DZ_COUNTDOWN_DEBOUNCE_EN defined: a 2-cycle btn_start glitch -> no load; a btn_start held 3+ cycles -> num=5 at edge 6.

Source files
------------

// File: rtl/dz_countdown.sv
// Button-driven countdown timer: synchronised (optionally debounced) start/pause buttons
// drive an IDLE/RUN/PAUSE/DONE FSM. Define DZ_COUNTDOWN_DEBOUNCE_EN to enable the debounce filter.
module dz_countdown #(
    parameter int TICK_DIV  = 1000,
    parameter int START_VAL = 5,
    parameter int DB_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    output logic [2:0] num,
    output logic       running,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    // Bit 0 carries the start button, bit 1 the pause button.
    logic [1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, armed_q, armed_d;
    logic [1:0] filt, btn_edge;
    logic       warm_q, warm_d;

    state_t      state_q, state_d;
    logic [2:0]  num_q, num_d;
    logic [PW-1:0] presc_q, presc_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic        tick;

    // A button is armed only after it has been seen released post-reset, so a
    // press held through reset release cannot produce an edge.
    always_comb begin
        s1_d     = {btn_pause, btn_start};
        s2_d     = s1_q;
        warm_d   = 1'b1;
        prev_d   = filt;
        armed_d  = armed_q | (~s1_q & {2{warm_q}});
        btn_edge = filt & ~prev_q & armed_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            warm_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            warm_q  <= warm_d;
        end
    end

`ifdef DZ_COUNTDOWN_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]         filt_q, filt_d;
    logic [1:0][CW-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    filt_d[i]   = s2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = s2_q;
`endif

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    // Start beats everything, including a simultaneous pause edge.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (btn_edge[0]) begin
            state_d = RUN;
            num_d   = 3'(START_VAL);
            presc_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (btn_edge[1]) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        presc_d = '0;
                        if (num_q <= 3'd1) begin
                            num_d   = 3'd0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            num_d = num_q - 3'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (btn_edge[1]) state_d = RUN;
                end
                default: begin
                    num_d   = 3'd0;
                    presc_d = '0;
                end
            endcase
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            num_q     <= 3'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign num     = num_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dz_countdown.sv
// Directed testbench for dz_countdown with TICK_DIV=4, START_VAL=5, DB_CYCLES=3.
module tb_dz_countdown;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       btn_pause;
    logic [2:0] num;
    logic       running;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int done_ref;

    dz_countdown #(.TICK_DIV(4), .START_VAL(5), .DB_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
        .num(num), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_start = 1'b0; btn_pause = 1'b0;
        step(2);
        n_cmp++; if (num !== 3'd0) begin n_bad++; $display("FAIL reset_num: got %0d want 0", num); end
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        step(4);
        btn_pause = 1'b1; step(1); btn_pause = 1'b0; step(4);
        n_cmp++; if (running !== 1'b0 || num !== 3'd0) begin n_bad++; $display("FAIL idle_pause: running=%b num=%0d want 0/0", running, num); end
    endtask

    task automatic test_basic;
        btn_start = 1'b1; step(1); btn_start = 1'b0; step(1);
        n_cmp++; if (num !== 3'd0) begin n_bad++; $display("FAIL basic_e2: num=%0d want 0", num); end
        step(1);
        n_cmp++; if (num !== 3'd5 || running !== 1'b1) begin n_bad++; $display("FAIL basic_load: num=%0d running=%b want 5/1", num, running); end
        step(3);
        n_cmp++; if (num !== 3'd5) begin n_bad++; $display("FAIL basic_e6: num=%0d want 5", num); end
        step(1);
        n_cmp++; if (num !== 3'd4) begin n_bad++; $display("FAIL basic_e7: num=%0d want 4", num); end
        step(4);
        n_cmp++; if (num !== 3'd3) begin n_bad++; $display("FAIL basic_e11: num=%0d want 3", num); end
        step(4);
        n_cmp++; if (num !== 3'd2) begin n_bad++; $display("FAIL basic_e15: num=%0d want 2", num); end
        step(4);
        n_cmp++; if (num !== 3'd1) begin n_bad++; $display("FAIL basic_e19: num=%0d want 1", num); end
        done_ref = done_cnt;
        step(3);
        n_cmp++; if (num !== 3'd1 || done !== 1'b0) begin n_bad++; $display("FAIL basic_e22: num=%0d done=%b want 1/0", num, done); end
        step(1);
        n_cmp++; if (num !== 3'd0 || done !== 1'b1 || running !== 1'b0) begin n_bad++; $display("FAIL basic_e23: num=%0d done=%b running=%b want 0/1/0", num, done, running); end
        step(1);
        n_cmp++; if (done !== 1'b0 || num !== 3'd0) begin n_bad++; $display("FAIL basic_e24: done=%b num=%0d want 0/0", done, num); end
        step(5);
        n_cmp++; if (num !== 3'd0 || running !== 1'b0) begin n_bad++; $display("FAIL basic_hold: num=%0d running=%b want 0/0", num, running); end
        n_cmp++; if (done_cnt - done_ref !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - done_ref); end
        btn_pause = 1'b1; step(1); btn_pause = 1'b0; step(4);
        n_cmp++; if (running !== 1'b0 || num !== 3'd0) begin n_bad++; $display("FAIL done_pause: running=%b num=%0d want 0/0", running, num); end
    endtask

    task automatic test_pause;
        btn_start = 1'b1; step(1); btn_start = 1'b0; step(2);
        step(8);
        n_cmp++; if (num !== 3'd3) begin n_bad++; $display("FAIL pause_pre: num=%0d want 3", num); end
        btn_pause = 1'b1; step(1); btn_pause = 1'b0; step(2);
        n_cmp++; if (running !== 1'b0 || num !== 3'd3) begin n_bad++; $display("FAIL pause_enter: running=%b num=%0d want 0/3", running, num); end
        step(10);
        n_cmp++; if (running !== 1'b0 || num !== 3'd3) begin n_bad++; $display("FAIL pause_hold: running=%b num=%0d want 0/3", running, num); end
        btn_pause = 1'b1; step(1); btn_pause = 1'b0; step(2);
        n_cmp++; if (running !== 1'b1 || num !== 3'd3) begin n_bad++; $display("FAIL pause_resume: running=%b num=%0d want 1/3", running, num); end
        step(1);
        n_cmp++; if (num !== 3'd3) begin n_bad++; $display("FAIL pause_partial: num=%0d want 3", num); end
        step(1);
        n_cmp++; if (num !== 3'd2) begin n_bad++; $display("FAIL pause_step: num=%0d want 2", num); end
    endtask

    task automatic test_restart;
        btn_start = 1'b1; step(1); btn_start = 1'b0; step(2);
        n_cmp++; if (num !== 3'd5 || running !== 1'b1) begin n_bad++; $display("FAIL restart_load: num=%0d running=%b want 5/1", num, running); end
        step(3);
        n_cmp++; if (num !== 3'd5) begin n_bad++; $display("FAIL restart_hold: num=%0d want 5", num); end
        step(1);
        n_cmp++; if (num !== 3'd4) begin n_bad++; $display("FAIL restart_step: num=%0d want 4", num); end
    endtask

    task automatic test_back_to_back;
        btn_pause = 1'b1; step(1); btn_pause = 1'b0; step(2);
        n_cmp++; if (running !== 1'b0 || num !== 3'd4) begin n_bad++; $display("FAIL both_paused: running=%b num=%0d want 0/4", running, num); end
        btn_start = 1'b1; btn_pause = 1'b1; step(1); btn_start = 1'b0; btn_pause = 1'b0; step(2);
        n_cmp++; if (running !== 1'b1 || num !== 3'd5) begin n_bad++; $display("FAIL both_load: running=%b num=%0d want 1/5", running, num); end
        step(3);
        n_cmp++; if (running !== 1'b1 || num !== 3'd5) begin n_bad++; $display("FAIL both_hold: running=%b num=%0d want 1/5", running, num); end
        step(1);
        n_cmp++; if (num !== 3'd4) begin n_bad++; $display("FAIL both_step: num=%0d want 4", num); end
    endtask

    task automatic test_reset_mid;
        done_ref = done_cnt;
        rst = 1'b1;
        #2;
        n_cmp++; if (num !== 3'd0 || running !== 1'b0) begin n_bad++; $display("FAIL async_rst: num=%0d running=%b want 0/0", num, running); end
        btn_start = 1'b1;
        step(2);
        rst = 1'b0;
        step(8);
        n_cmp++; if (num !== 3'd0 || running !== 1'b0) begin n_bad++; $display("FAIL held_through_rst: num=%0d running=%b want 0/0", num, running); end
        n_cmp++; if (done_cnt !== done_ref) begin n_bad++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - done_ref); end
        btn_start = 1'b0; step(3);
        btn_start = 1'b1; step(1); btn_start = 1'b0; step(2);
        n_cmp++; if (num !== 3'd5 || running !== 1'b1) begin n_bad++; $display("FAIL rearm_load: num=%0d running=%b want 5/1", num, running); end
    endtask

    task automatic test_debounce;
        btn_start = 1'b1; step(2); btn_start = 1'b0;
        step(3);
        n_cmp++; if (num !== 3'd0 || running !== 1'b0) begin n_bad++; $display("FAIL glitch_e5: num=%0d running=%b want 0/0", num, running); end
        step(5);
        n_cmp++; if (num !== 3'd0 || running !== 1'b0) begin n_bad++; $display("FAIL glitch_e10: num=%0d running=%b want 0/0", num, running); end
        btn_start = 1'b1; step(4); btn_start = 1'b0;
        step(1);
        n_cmp++; if (num !== 3'd0) begin n_bad++; $display("FAIL db_e5: num=%0d want 0", num); end
        step(1);
        n_cmp++; if (num !== 3'd5 || running !== 1'b1) begin n_bad++; $display("FAIL db_e6: num=%0d running=%b want 5/1", num, running); end
        step(4);
        n_cmp++; if (num !== 3'd4) begin n_bad++; $display("FAIL db_e10: num=%0d want 4", num); end
        btn_pause = 1'b1; step(1); btn_pause = 1'b0; step(8);
        n_cmp++; if (running !== 1'b1 || num !== 3'd2) begin n_bad++; $display("FAIL db_pause_glitch: running=%b num=%0d want 1/2", running, num); end
        rst = 1'b1;
        #2;
        n_cmp++; if (num !== 3'd0 || running !== 1'b0) begin n_bad++; $display("FAIL db_rst: num=%0d running=%b want 0/0", num, running); end
        step(2);
        rst = 1'b0;
        step(4);
    endtask

    initial begin
        test_reset;
`ifdef DZ_COUNTDOWN_DEBOUNCE_EN
        test_debounce;
`else
        test_basic;
        test_pause;
        test_restart;
        test_back_to_back;
        test_reset_mid;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
